// File: rtl/irq_controller_if.sv
// CPU memory-bus signals seen by the interrupt controller.
// The CPU drives address/data/strobes; the controller returns read data, its enable and irq.
interface irq_controller_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        read;
  logic        write;
  logic        iack;
  logic [15:0] data_out;
  logic        data_oe;
  logic        irq;

  modport master (
    output addr, data_in, read, write, iack,
    input  data_out, data_oe, irq
  );

  modport slave (
    input  addr, data_in, read, write, iack,
    output data_out, data_oe, irq
  );
endinterface

// File: rtl/irq_controller.sv
// Prioritised, nesting interrupt controller: synchronised edge-latched requests,
// memory-mapped mask/pending/in-service registers and a vectored acknowledge.
module irq_controller #(
  parameter logic [15:0] BASE = 16'hFEF0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       src,
  irq_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    REG_PENDING   = 3'd0,
    REG_MASK      = 3'd1,
    REG_INSERVICE = 3'd2,
    REG_EOI       = 3'd3,
    REG_VECBASE   = 3'd4
  } reg_sel_e;

  logic [7:0]  sync1, sync2, sync_prev;
  logic [1:0]  settle;
  logic [7:0]  pending, mask, inservice;
  logic [11:0] vec_hi;

  logic        hit, settled;
  logic        wr_pending, wr_mask, wr_eoi, wr_vec;
  logic [7:0]  req, rise, ack_bits, eoi_bits;
  logic [3:0]  p, s;
  logic        irq_int;
  logic [7:0]  pending_next, inservice_next;

  function automatic logic [3:0] lowest(input logic [7:0] v);
    logic found;
    lowest = 4'd8;
    found  = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (v[i] && !found) begin
        lowest = 4'(i);
        found  = 1'b1;
      end
    end
  endfunction

  function automatic logic [7:0] onehot(input logic [3:0] idx);
    logic [8:0] t;
    t = 9'd1 << idx;
    onehot = t[7:0];
  endfunction

  assign hit     = (bus.addr[15:3] == BASE[15:3]);
  assign settled = (settle == 2'd3);

  always_comb begin
    wr_pending = 1'b0;
    wr_mask    = 1'b0;
    wr_eoi     = 1'b0;
    wr_vec     = 1'b0;
    if (bus.write && hit) begin
      case (bus.addr[2:0])
        REG_PENDING: wr_pending = 1'b1;
        REG_MASK:    wr_mask    = 1'b1;
        REG_EOI:     wr_eoi     = 1'b1;
        REG_VECBASE: wr_vec     = 1'b1;
        default:     ;
      endcase
    end
  end

  // Edge detection stays off until the chain has refilled after reset, so the
  // previous-value flop has caught up with any source held high through reset.
  assign rise = settled ? (sync2 & ~sync_prev) : '0;

  assign req     = pending & mask;
  assign p       = lowest(req);
  assign s       = lowest(inservice);
  assign irq_int = (req != '0) && (p < s);

  assign ack_bits = (bus.iack && irq_int) ? onehot(p) : '0;
  assign eoi_bits = wr_eoi ? onehot(s) : '0;

  always_comb begin
    pending_next   = (pending & ~((wr_pending ? bus.data_in[7:0] : '0) | ack_bits)) | rise;
    inservice_next = (inservice & ~eoi_bits) | ack_bits;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      sync_prev <= '0;
      settle    <= '0;
      pending   <= '0;
      mask      <= '0;
      inservice <= '0;
      vec_hi    <= '0;
    end else begin
      sync1     <= src;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (!settled) settle <= settle + 2'd1;
      pending   <= pending_next;
      inservice <= inservice_next;
      if (wr_mask) mask   <= bus.data_in[7:0];
      if (wr_vec)  vec_hi <= bus.data_in[15:4];
    end
  end

  always_comb begin
    bus.data_out = '0;
    if (bus.iack) begin
      bus.data_out = irq_int ? {vec_hi, 1'b0, p[2:0]} : {vec_hi, 4'hF};
    end else if (bus.read && hit) begin
      case (bus.addr[2:0])
        REG_PENDING:   bus.data_out = {8'h00, pending};
        REG_MASK:      bus.data_out = {8'h00, mask};
        REG_INSERVICE: bus.data_out = {8'h00, inservice};
        REG_VECBASE:   bus.data_out = {vec_hi, 4'h0};
        default:       bus.data_out = '0;
      endcase
    end
  end

  assign bus.data_oe = bus.iack || (bus.read && hit);
  assign bus.irq     = irq_int;

endmodule
